ntt_lane_gather: RTL and testbench

NTT_LANE_GATHER -- requirements
Module: ntt_lane_gather

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_lane_bank.sv | 46 ++++
 rtl/ntt_lane_gather.sv | 89 ++++++++
 tb/tb_ntt_lane_gather.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT lane gather: lane geometry, bank state, and
// the 3-bit bit-reversal used to place samples for the radix-2/4/8 butterfly.
package ntt_pkg;

  localparam int NUM_LANES  = 8;
  localparam int LANE_IDX_W = 3;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  function automatic logic [LANE_IDX_W-1:0] bitrev3(input logic [LANE_IDX_W-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ntt_lane_bank.sv
// One ping-pong bank: eight lane registers, fill state and padded flag.
// A pop clears every lane so unwritten lanes of the next frame read as zero.
module ntt_lane_bank
  import ntt_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic [LANE_IDX_W-1:0]       i_wr_lane,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic                        i_complete,
  input  logic                        i_padded,
  input  logic                        i_pop,
  output bank_state_e                 o_state,
  output logic [NUM_LANES*WIDTH-1:0]  o_data,
  output logic                        o_padded
);

  logic [NUM_LANES-1:0][WIDTH-1:0] r_lane;
  bank_state_e                     r_state;
  logic                            r_padded;

  // Write and pop never target the same bank: writes need !FULL, pops need FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane   <= '0;
      r_state  <= BANK_EMPTY;
      r_padded <= 1'b0;
    end else if (i_pop) begin
      r_lane   <= '0;
      r_state  <= BANK_EMPTY;
      r_padded <= 1'b0;
    end else if (i_wr_en) begin
      r_lane[i_wr_lane] <= i_wr_data;
      r_state           <= i_complete ? BANK_FULL : BANK_FILLING;
      if (i_complete) r_padded <= i_padded;
    end
  end

  assign o_state  = r_state;
  assign o_data   = r_lane;
  assign o_padded = r_padded;

endmodule

// File: rtl/ntt_lane_gather.sv
// Gathers a coefficient stream into 8-lane frames for the butterfly core,
// double-buffered so one frame fills while the other waits to be consumed.
module ntt_lane_gather #(
  parameter int WIDTH     = 18,
  parameter int NUM_LANES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_last,
  input  logic                        bitrev_en,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [NUM_LANES*WIDTH-1:0]  frame_data,
  output logic                        frame_padded
);
  import ntt_pkg::*;

  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [LANE_IDX_W-1:0] r_wr_idx;
  logic                  r_bitrev;

  bank_state_e                    w_state [2];
  logic [NUM_LANES*WIDTH-1:0]     w_data  [2];
  logic                           w_pad   [2];

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_brev;
  logic                  w_idx_last;
  logic                  w_complete;
  logic                  w_padded;
  logic [LANE_IDX_W-1:0] w_lane;

  assign in_ready    = rst_n && (w_state[r_wr_ptr] != BANK_FULL);
  assign frame_valid = (w_state[r_rd_ptr] == BANK_FULL);
  assign w_accept    = in_valid && in_ready;
  assign w_pop       = frame_valid && frame_ready;

  // Sample 0 uses bitrev_en directly; the rest of the frame uses the latched flag.
  assign w_brev     = (r_wr_idx == '0) ? bitrev_en : r_bitrev;
  assign w_lane     = w_brev ? bitrev3(r_wr_idx) : r_wr_idx;
  assign w_idx_last = (r_wr_idx == LANE_IDX_W'(NUM_LANES-1));
  assign w_complete = w_accept && (w_idx_last || in_last);
  assign w_padded   = in_last && !w_idx_last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_lane_bank #(.WIDTH(WIDTH)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_accept && (r_wr_ptr == 1'(b))),
      .i_wr_lane  (w_lane),
      .i_wr_data  (in_data),
      .i_complete (w_complete),
      .i_padded   (w_padded),
      .i_pop      (w_pop && (r_rd_ptr == 1'(b))),
      .o_state    (w_state[b]),
      .o_data     (w_data[b]),
      .o_padded   (w_pad[b])
    );
  end

  assign frame_data   = w_data[r_rd_ptr];
  assign frame_padded = w_pad[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_wr_idx <= '0;
      r_bitrev <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_wr_idx == '0) r_bitrev <= bitrev_en;
        if (w_complete) begin
          r_wr_idx <= '0;
          r_wr_ptr <= ~r_wr_ptr;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
    end
  end

endmodule

// File: tb/tb_ntt_lane_gather.sv
// Directed bench for ntt_lane_gather: a table of single frames plus
// hand-written backpressure, streaming and mid-frame reset sequences.
module tb_ntt_lane_gather;
  localparam int W = 18;
  typedef logic [7:0][W-1:0] frm_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last, bitrev_en;
  logic [W-1:0]  in_data;
  logic          frame_valid, frame_ready, frame_padded;
  logic [8*W-1:0] frame_data;

  int compares = 0;
  int fails    = 0;
  frm_t got_q[$];

  ntt_lane_gather #(.WIDTH(W), .NUM_LANES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bitrev_en(bitrev_en),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .frame_padded(frame_padded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_valid && frame_ready) got_q.push_back(frame_data);

  typedef struct packed {
    int   n;
    frm_t d;
    logic br0;
    logic brr;
    logic last;
    frm_t exp;
    logic pad;
  } vec_t;

  function automatic frm_t f8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    frm_t r;
    r[0] = W'(a0); r[1] = W'(a1); r[2] = W'(a2); r[3] = W'(a3);
    r[4] = W'(a4); r[5] = W'(a5); r[6] = W'(a6); r[7] = W'(a7);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic last, input logic br);
    int t;
    t = 0;
    in_data = d; in_last = last; bitrev_en = br; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      compares++; fails++;
      $display("FAIL push_timeout: in_ready stuck 0 for data %0d", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop_one();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("frame_count", 32'(got_q.size()), 32'(n));
  endtask

  vec_t vt[9];
  int   stalls;

  initial begin
    vt[0] = '{n:8, d:f8(1,2,3,4,5,6,7,8),        br0:0, brr:0, last:0, exp:f8(1,2,3,4,5,6,7,8),        pad:0};
    vt[1] = '{n:8, d:f8(1,2,3,4,5,6,7,8),        br0:1, brr:1, last:0, exp:f8(1,5,3,7,2,6,4,8),        pad:0};
    vt[2] = '{n:3, d:f8(10,20,30,0,0,0,0,0),     br0:0, brr:0, last:1, exp:f8(10,20,30,0,0,0,0,0),     pad:1};
    vt[3] = '{n:8, d:f8(101,102,103,104,105,106,107,108), br0:0, brr:0, last:1,
              exp:f8(101,102,103,104,105,106,107,108), pad:0};
    vt[4] = '{n:1, d:f8('h3FFFF,0,0,0,0,0,0,0),  br0:1, brr:1, last:1, exp:f8('h3FFFF,0,0,0,0,0,0,0), pad:1};
    vt[5] = '{n:5, d:f8(11,12,13,14,15,0,0,0),   br0:1, brr:1, last:1, exp:f8(11,15,13,0,12,0,14,0),   pad:1};
    vt[6] = '{n:8, d:f8(21,22,23,24,25,26,27,28), br0:0, brr:1, last:0, exp:f8(21,22,23,24,25,26,27,28), pad:0};
    vt[7] = '{n:8, d:f8(31,32,33,34,35,36,37,38), br0:1, brr:0, last:0, exp:f8(31,35,33,37,32,36,34,38), pad:0};
    vt[8] = '{n:7, d:f8(41,42,43,44,45,46,47,0), br0:1, brr:1, last:1, exp:f8(41,45,43,47,42,46,44,0),  pad:1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; bitrev_en = 1'b0;
    in_data = '0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",    in_ready,     0);
    chk("rst_frame_valid", frame_valid,  0);
    chk("rst_frame_data",  frame_data,   0);
    chk("rst_padded",      frame_padded, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single frames from the table, held then popped by hand.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < vt[v].n; k++) begin
        if (k == vt[v].n - 1) chk($sformatf("v%0d_valid_before", v), frame_valid, 0);
        push(vt[v].d[k], (k == vt[v].n - 1) && vt[v].last, (k == 0) ? vt[v].br0 : vt[v].brr);
      end
      chk($sformatf("v%0d_valid", v),    frame_valid,  1);
      chk($sformatf("v%0d_data", v),     frame_data,   vt[v].exp);
      chk($sformatf("v%0d_padded", v),   frame_padded, vt[v].pad);
      chk($sformatf("v%0d_in_ready", v), in_ready,     1);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_data_held", v), frame_data, vt[v].exp);
      pop_one();
      chk($sformatf("v%0d_valid_after_pop", v), frame_valid, 0);
    end

    // Both banks full under backpressure, then drain in order.
    got_q.delete();
    for (int i = 1; i <= 16; i++) push(W'(i), 1'b0, 1'b0);
    chk("bp_in_ready_full", in_ready,    0);
    chk("bp_valid",         frame_valid, 1);
    chk("bp_head",          frame_data,  f8(1,2,3,4,5,6,7,8));
    frame_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_pop", in_ready,   1);
    chk("bp_second_frame",       frame_data, f8(9,10,11,12,13,14,15,16));
    for (int i = 17; i <= 24; i++) push(W'(i), 1'b0, 1'b0);
    wait_frames(3);
    if (got_q.size() == 3) begin
      chk("bp_f0", got_q[0], f8(1,2,3,4,5,6,7,8));
      chk("bp_f1", got_q[1], f8(9,10,11,12,13,14,15,16));
      chk("bp_f2", got_q[2], f8(17,18,19,20,21,22,23,24));
    end

    // Back-to-back stream at one sample per cycle.
    got_q.delete();
    stalls = 0;
    frame_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = W'(1000 + i); in_valid = 1'b1; in_last = 1'b0; bitrev_en = 1'b0;
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_stalls", 32'(stalls), 0);
    wait_frames(8);
    if (got_q.size() == 8)
      for (int f = 0; f < 8; f++)
        chk($sformatf("stream_f%0d", f), got_q[f],
            f8(1000+8*f, 1001+8*f, 1002+8*f, 1003+8*f, 1004+8*f, 1005+8*f, 1006+8*f, 1007+8*f));
    frame_ready = 1'b0;

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 5; i++) push(W'(500 + i), 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",    in_ready,     0);
    chk("mrst_frame_valid", frame_valid,  0);
    chk("mrst_frame_data",  frame_data,   0);
    chk("mrst_padded",      frame_padded, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) push(W'(i), 1'b0, 1'b0);
    chk("mrst_valid",  frame_valid,  1);
    chk("mrst_frame",  frame_data,   f8(1,2,3,4,5,6,7,8));
    chk("mrst_padded2", frame_padded, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
